// File: rtl/vga_sprite_compositor.sv
// -----------------------------------------------------------------------------
// vga_sprite_compositor
//
// VGA output stage for the boids display. A clock-enable ("pix_en") derived
// from a modulo-CLK_DIV counter paces all pixel-rate logic, so the whole block
// runs on the single system clock. The horizontal and vertical counters feed a
// two-stage pipeline:
//   P0  counters (hc, vc)
//   P1  framebuffer read address, sprite hit/priority, sync/active
//   P2  framebuffer data sampled, colour chosen, pins registered
// The 1-bit framebuffer can be shown at 2**SCALE_SHIFT scale. Up to
// NUM_SPRITES solid square sprites are overlaid; their parameters are
// captured into shadow registers once per frame so a frame never tears.
//
// Ports
//   clk          system clock
//   reset        asynchronous assert, active-low reset
//   sprite_x     sprite i left edge,  bits [10i+9:10i]
//   sprite_y     sprite i top edge,   bits [9i+8:9i]
//   sprite_color sprite i RGB444,     bits [12i+11:12i]
//   sprite_en    per-sprite enable
//   fb_addr      registered framebuffer read address
//   fb_data      framebuffer read data (1 = boid present)
//   hSync/vSync  active-low syncs, aligned with the colour outputs
//   VGA_R/G/B    RGB444 colour outputs (0 outside the visible area)
//   active       high while the output pixel is visible
//   frame_end    one-clk pulse at the start of vertical blanking
//   frame_count  frames completed, wraps at 16 bits
// -----------------------------------------------------------------------------
module vga_sprite_compositor #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter int          CLK_DIV     = 4,
  parameter int          SCALE_SHIFT = 0,
  parameter int          NUM_SPRITES = 2,
  parameter int          SPRITE_SIZE = 10,
  parameter logic [11:0] BG_COLOR    = 12'hFFF,
  parameter logic [11:0] FG_COLOR    = 12'h000,
  parameter int          ADDR_W      = $clog2((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [10*NUM_SPRITES-1:0] sprite_x,
  input  logic [9*NUM_SPRITES-1:0]  sprite_y,
  input  logic [12*NUM_SPRITES-1:0] sprite_color,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  output logic [ADDR_W-1:0]         fb_addr,
  input  logic                      fb_data,
  output logic                      hSync,
  output logic                      vSync,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B,
  output logic                      active,
  output logic                      frame_end,
  output logic [15:0]               frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int PIX_W   = $clog2(CLK_DIV);
  // Sprite bound sums are evaluated wider than any coordinate so a sprite
  // near the right/bottom edge clips instead of wrapping to the left/top.
  localparam int CMP_W   = 12;

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_ACT_L   = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0]  V_ACT_L   = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]  V_ACT_END = VC_W'(V_ACTIVE - 1);
  localparam logic [HC_W-1:0]  HS_START  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]  HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0]  VS_START  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]  VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CMP_W-1:0] SIZE_C    = CMP_W'(SPRITE_SIZE);
  localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  // ---------------------------------------------------------------------------
  // Pixel enable
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] pix_cnt_reg;
  logic             pix_en;

  assign pix_en = (pix_cnt_reg == PIX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_reg <= '0;
    end else if (pix_en) begin
      pix_cnt_reg <= '0;
    end else begin
      pix_cnt_reg <= pix_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // P0: horizontal / vertical counters
  // ---------------------------------------------------------------------------
  logic [HC_W-1:0] hc_reg;
  logic [VC_W-1:0] vc_reg;
  logic            h_last;
  logic            v_last;
  logic            frame_wrap;

  assign h_last     = (hc_reg == H_LAST);
  assign v_last     = (vc_reg == V_LAST);
  assign frame_wrap = pix_en && h_last && v_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc_reg <= '0;
      vc_reg <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hc_reg <= '0;
        vc_reg <= v_last ? '0 : vc_reg + 1'b1;
      end else begin
        hc_reg <= hc_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sprite shadows: captured only on the pixel where both counters wrap, so
  // every displayed frame uses one consistent set of sprite parameters.
  // ---------------------------------------------------------------------------
  logic [10*NUM_SPRITES-1:0] shadow_x_reg;
  logic [9*NUM_SPRITES-1:0]  shadow_y_reg;
  logic [12*NUM_SPRITES-1:0] shadow_color_reg;
  logic [NUM_SPRITES-1:0]    shadow_en_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_x_reg     <= '0;
      shadow_y_reg     <= '0;
      shadow_color_reg <= '0;
      shadow_en_reg    <= '0;
    end else if (frame_wrap) begin
      shadow_x_reg     <= sprite_x;
      shadow_y_reg     <= sprite_y;
      shadow_color_reg <= sprite_color;
      shadow_en_reg    <= sprite_en;
    end
  end

  // ---------------------------------------------------------------------------
  // P0 combinational decode: visibility, syncs, sprite hits
  // ---------------------------------------------------------------------------
  logic visible;
  logic hs_next;
  logic vs_next;

  assign visible = (hc_reg < H_ACT_L) && (vc_reg < V_ACT_L);
  assign hs_next = !((hc_reg >= HS_START) && (hc_reg < HS_END));
  assign vs_next = !((vc_reg >= VS_START) && (vc_reg < VS_END));

  logic [CMP_W-1:0]       hc_c;
  logic [CMP_W-1:0]       vc_c;
  logic [NUM_SPRITES-1:0] hit_vec;

  assign hc_c = CMP_W'(hc_reg);
  assign vc_c = CMP_W'(vc_reg);

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
    logic [CMP_W-1:0] sx_c;
    logic [CMP_W-1:0] sy_c;
    assign sx_c = CMP_W'(shadow_x_reg[10*gi +: 10]);
    assign sy_c = CMP_W'(shadow_y_reg[9*gi +: 9]);
    assign hit_vec[gi] = shadow_en_reg[gi]
                      && (hc_c >= sx_c) && (hc_c < sx_c + SIZE_C)
                      && (vc_c >= sy_c) && (vc_c < sy_c + SIZE_C);
  end

  // Lowest-index hit sprite wins; scanning from the top down lets the lowest
  // index overwrite any higher one.
  logic        spr_hit_next;
  logic [11:0] spr_color_next;

  always_comb begin
    spr_hit_next   = 1'b0;
    spr_color_next = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        spr_hit_next   = 1'b1;
        spr_color_next = shadow_color_reg[12*i +: 12];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // P1: framebuffer address and per-pixel attributes
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fb_addr_next;
  logic              spr_hit_p1_reg;
  logic [11:0]       spr_color_p1_reg;
  logic              hs_p1_reg;
  logic              vs_p1_reg;
  logic              act_p1_reg;

  assign fb_addr_next = ADDR_W'(hc_reg >> SCALE_SHIFT)
                      + ROW_W * ADDR_W'(vc_reg >> SCALE_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_addr          <= '0;
      spr_hit_p1_reg   <= 1'b0;
      spr_color_p1_reg <= '0;
      hs_p1_reg        <= 1'b1;
      vs_p1_reg        <= 1'b1;
      act_p1_reg       <= 1'b0;
    end else if (pix_en) begin
      // Address holds through blanking so the memory sees no spurious reads.
      if (visible) begin
        fb_addr <= fb_addr_next;
      end
      spr_hit_p1_reg   <= spr_hit_next;
      spr_color_p1_reg <= spr_color_next;
      hs_p1_reg        <= hs_next;
      vs_p1_reg        <= vs_next;
      act_p1_reg       <= visible;
    end
  end

  // ---------------------------------------------------------------------------
  // P2: colour select and output registers
  // ---------------------------------------------------------------------------
  logic [11:0] color_next;

  always_comb begin
    color_next = fb_data ? FG_COLOR : BG_COLOR;
    if (spr_hit_p1_reg) begin
      color_next = spr_color_p1_reg;
    end
    if (!act_p1_reg) begin
      color_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hSync  <= 1'b1;
      vSync  <= 1'b1;
      active <= 1'b0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else if (pix_en) begin
      hSync  <= hs_p1_reg;
      vSync  <= vs_p1_reg;
      active <= act_p1_reg;
      VGA_R  <= color_next[11:8];
      VGA_G  <= color_next[7:4];
      VGA_B  <= color_next[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame end pulse and frame counter: fire on the pixel where vc steps from
  // the last visible line into vertical blanking.
  // ---------------------------------------------------------------------------
  logic frame_end_next;

  assign frame_end_next = pix_en && h_last && (vc_reg == V_ACT_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_end   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_end <= frame_end_next;
      if (frame_end_next) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// -----------------------------------------------------------------------------
// Bench for vga_sprite_compositor using a reduced raster so several frames fit
// in a short run. Two instances: dut0 at 1x scale with two sprites, dut1 at
// 2x scale with sprites disabled. Expected pixels are queued up front from a
// model of the raster; monitors pop and compare whenever a pixel is presented.
//
// Reduced timing: 16+2+3+3 = 24 px per line, 12+1+2+2 = 17 lines per frame,
// CLK_DIV = 2, SPRITE_SIZE = 4. One frame = 408 pixels = 816 clk.
// Output for global pixel g appears after posedge 2*(g+2) counted from the
// reset release.
// -----------------------------------------------------------------------------
module tb_vga_sprite_compositor;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 3;
  localparam int VA = 12, VFP = 1, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam int SS = 4;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;
  // Reset is asserted mid-frame 3 while P0 = (hc=10, vc=11).
  localparam int G_RST   = 3 * FRAME + 11 * HT + 10;
  localparam int RST_CYC = CD * G_RST + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] sprite_x;
  logic [17:0] sprite_y;
  logic [23:0] sprite_color;
  logic [1:0]  sprite_en;

  logic [7:0]  fb_addr0;
  logic        fb_data0;
  logic        hs0, vs0, act0, fe0;
  logic [3:0]  r0, g0, b0;
  logic [15:0] fc0;

  logic [5:0]  fb_addr1;
  logic        fb_data1;
  logic        hs1, vs1, act1, fe1;
  logic [3:0]  r1, g1, b1;
  logic [15:0] fc1;

  vga_sprite_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .SCALE_SHIFT(0), .NUM_SPRITES(2), .SPRITE_SIZE(SS)
  ) dut0 (
    .clk(clk), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_color(sprite_color), .sprite_en(sprite_en),
    .fb_addr(fb_addr0), .fb_data(fb_data0),
    .hSync(hs0), .vSync(vs0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .active(act0), .frame_end(fe0), .frame_count(fc0)
  );

  vga_sprite_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .SCALE_SHIFT(1), .NUM_SPRITES(2), .SPRITE_SIZE(SS)
  ) dut1 (
    .clk(clk), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_color(sprite_color), .sprite_en(2'b00),
    .fb_addr(fb_addr1), .fb_data(fb_data1),
    .hSync(hs1), .vSync(vs1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .active(act1), .frame_end(fe1), .frame_count(fc1)
  );

  // Framebuffer models with 1-clk read latency, one bit set in each.
  always @(posedge clk) begin
    fb_data0 <= (fb_addr0 == 8'd17);  // pixel (1,1) at 1x
    fb_data1 <= (fb_addr1 == 6'd9);   // block (2..3,2..3) at 2x
  end

  // Clock cycles since reset release.
  int cyc;
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, int act_v, int exp_v);
    tests++;
    if (act_v != exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
    end
  endfunction

  // Sprite configuration seen by each frame (shadows taken at frame start).
  int cfg_x[4][2], cfg_y[4][2], cfg_c[4][2], cfg_e[4][2];

  function automatic logic [14:0] exp_pix(int g, int s, int fb_set, bit use_spr);
    int f, n, x, y;
    logic hs, vs, act;
    logic [11:0] rgb;
    f = g / FRAME;
    n = g % FRAME;
    x = n % HT;
    y = n / HT;
    hs  = !(x >= HA + HFP && x < HA + HFP + HS);
    vs  = !(y >= VA + VFP && y < VA + VFP + VS);
    act = (x < HA) && (y < VA);
    rgb = 12'h000;
    if (act) begin
      rgb = (((x >> s) + (HA >> s) * (y >> s)) == fb_set) ? 12'h000 : 12'hFFF;
      if (use_spr) begin
        for (int i = 1; i >= 0; i--) begin
          if (cfg_e[f][i] != 0 && x >= cfg_x[f][i] && x < cfg_x[f][i] + SS
              && y >= cfg_y[f][i] && y < cfg_y[f][i] + SS)
            rgb = 12'(cfg_c[f][i]);
        end
      end
    end
    return {hs, vs, act, rgb};
  endfunction

  logic [14:0] q0[$];
  logic [14:0] q1[$];
  int          fe_cyc_q[$];
  int          fe_cnt_q[$];
  bit          mon_on = 1'b0;
  int          max_addr0 = 0;
  int          max_addr1 = 0;

  // Pixel monitor: one output pixel per pix_en period once the pipeline fills.
  always @(negedge clk) begin
    if (mon_on && reset) begin
      if (int'(fb_addr0) > max_addr0) max_addr0 = int'(fb_addr0);
      if (int'(fb_addr1) > max_addr1) max_addr1 = int'(fb_addr1);
      if (cyc >= 2 * CD && (cyc % CD) == 0) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          check("pixel_queue_underrun", 1, 0);
        end else begin
          logic [14:0] e0, e1;
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          check($sformatf("pix1x_g%0d", cyc / CD - 2),
                int'({hs0, vs0, act0, r0, g0, b0}), int'(e0));
          check($sformatf("pix2x_g%0d", cyc / CD - 2),
                int'({hs1, vs1, act1, r1, g1, b1}), int'(e1));
        end
      end
    end
  end

  // Frame-end monitor: pulse timing, width and frame counter.
  logic fe_prev = 1'b0;
  always @(negedge clk) begin
    if (reset && fe0) begin
      check("frame_end_width", int'(fe_prev), 0);
      if (fe_cyc_q.size() == 0) begin
        check("frame_end_unexpected", cyc, -1);
      end else begin
        int ec, en;
        ec = fe_cyc_q.pop_front();
        en = fe_cnt_q.pop_front();
        check("frame_end_cycle", cyc, ec);
        check("frame_count_at_end", int'(fc0), en);
        $display("[TB] frame_end at cycle %0d, frame_count=%0d", cyc, fc0);
      end
    end
    fe_prev = reset && fe0;
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_hsync"}, int'(hs0), 1);
    check({tag, "_vsync"}, int'(vs0), 1);
    check({tag, "_rgb"}, int'({r0, g0, b0}), 0);
    check({tag, "_active"}, int'(act0), 0);
    check({tag, "_fb_addr"}, int'(fb_addr0), 0);
    check({tag, "_frame_end"}, int'(fe0), 0);
    check({tag, "_frame_count"}, int'(fc0), 0);
    check({tag, "_2x_fb_addr"}, int'(fb_addr1), 0);
    check({tag, "_2x_hsync"}, int'(hs1), 1);
  endtask

  task automatic set_sprites(int f);
    for (int i = 0; i < 2; i++) begin
      sprite_x[10*i +: 10]     = 10'(cfg_x[f][i]);
      sprite_y[9*i +: 9]       = 9'(cfg_y[f][i]);
      sprite_color[12*i +: 12] = 12'(cfg_c[f][i]);
      sprite_en[i]             = (cfg_e[f][i] != 0);
    end
  endtask

  initial begin
    // frame 0: shadows cleared by reset, nothing shown
    cfg_x[0] = '{3, 5};    cfg_y[0] = '{2, 2};   cfg_c[0] = '{'hF00, 'h0F0}; cfg_e[0] = '{0, 0};
    // frame 1: overlapping pair, sprite0 wins x=5..6
    cfg_x[1] = '{3, 5};    cfg_y[1] = '{2, 2};   cfg_c[1] = '{'hF00, 'h0F0}; cfg_e[1] = '{1, 1};
    // frame 2: sprite0 in the bottom-right corner, clipped to 2x2
    cfg_x[2] = '{14, 5};   cfg_y[2] = '{10, 2};  cfg_c[2] = '{'hF00, 'h0F0}; cfg_e[2] = '{1, 0};
    // frame 3: sprite0 moved to the left edge (changed mid-frame 2)
    cfg_x[3] = '{0, 5};    cfg_y[3] = '{10, 2};  cfg_c[3] = '{'hF00, 'h0F0}; cfg_e[3] = '{1, 0};

    set_sprites(1);
    for (int g = 0; g <= G_RST - 2; g++) begin
      q0.push_back(exp_pix(g, 0, 17, 1'b1));
      q1.push_back(exp_pix(g, 1, 9, 1'b0));
    end
    // frame_end follows the pix_en ending line VA-1 of each frame
    for (int f = 0; f < 3; f++) begin
      fe_cyc_q.push_back(CD * (f * FRAME + VA * HT));
      fe_cnt_q.push_back(f + 1);
    end

    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    $display("[TB] power-on reset values checked");

    reset  = 1'b1;
    mon_on = 1'b1;
    $display("[TB] released reset, streaming frames 0..3");

    while (cyc != CD * (FRAME + FRAME / 2)) @(negedge clk);
    set_sprites(2);
    $display("[TB] mid-frame 1: sprite0 moved to (14,10), sprite1 disabled");

    while (cyc != CD * (2 * FRAME + FRAME / 2)) @(negedge clk);
    set_sprites(3);
    $display("[TB] mid-frame 2: sprite0 x changed to 0");

    while (cyc != RST_CYC) @(negedge clk);
    check("frame_count_before_reset", int'(fc0), 3);
    mon_on = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs("async");
    $display("[TB] reset asserted mid-frame at P0=(10,11)");

    check("pixel_queue_drained", q0.size() + q1.size(), 0);
    check("frame_end_queue_drained", fe_cyc_q.size(), 0);
    check("max_fb_addr_1x", max_addr0, HA * VA - 1);
    check("max_fb_addr_2x", max_addr1, (HA / 2) * (VA / 2) - 1);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("[TB] released reset after 3 clk");

    // First frame after release restarts at (0,0): pixel 0 is visible at
    // cycle 2*CD, and the first hSync low is x=HA+HFP of line 0.
    while (cyc != 2 * CD - 1) @(negedge clk);
    check("restart_active_before_fill", int'(act0), 0);
    @(negedge clk);
    check("restart_active_px0", int'(act0), 1);
    check("restart_rgb_px0", int'({r0, g0, b0}), 'hFFF);
    begin
      int hs_cyc;
      hs_cyc = -1;
      for (int k = 0; k < 200 && hs_cyc < 0; k++) begin
        if (hs0 == 1'b0) hs_cyc = cyc;
        else @(negedge clk);
      end
      check("restart_first_hsync_cycle", hs_cyc, CD * (HA + HFP + 2));
      check("restart_vsync_line0", int'(vs0), 1);
      check("restart_frame_count", int'(fc0), 0);
      $display("[TB] first hSync low after restart at cycle %0d", hs_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
